bus_timer_slv: RTL and testbench

- Memory-mapped timer peripheral that acts as a slave on the system bus.
- Responds to the slave-side address, write-enable, valid and bidirectional data signals.
- Provides a prescaled up-counter, a compare register, a sticky match flag and a level interrupt to the CPU.
- Occupies one slave slot on the bus.

---
 rtl/bus_timer_slv_if.sv | 11 +
 rtl/bus_timer_slv.sv | 154 +++++++++++++++
 tb/tb_bus_timer_slv.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_slv_if.sv
// Slave-side bus handshake for the timer peripheral: byte address, direction and access strobe.
interface bus_timer_slv_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] addr_bus_slv;
  logic                  we_ctrl_slv;
  logic                  valid_ctrl_slv;

  modport master (output addr_bus_slv, output we_ctrl_slv, output valid_ctrl_slv);
  modport slave  (input  addr_bus_slv, input  we_ctrl_slv, input  valid_ctrl_slv);
endinterface

// File: rtl/bus_timer_slv.sv
// Memory-mapped prescaled timer slave: CTRL/PRESC/COUNT/CMP/STATUS, sticky match, level irq.
// Optional input capture (CAPT at 0x14, STATUS.CAPF) is built when TIMER_CAPTURE_EN is defined.
module bus_timer_slv #(
  parameter int DATA_WIDTH   = 32,
  parameter int PRESC_WIDTH  = 16,
  parameter int REG_ADDR_LSB = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bus_timer_slv_if.slave        bus,
  inout  wire  [DATA_WIDTH-1:0] data_bus_slv,
`ifdef TIMER_CAPTURE_EN
  input  logic                  cap_in,
`endif
  output logic                  irq
);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_PRESC  = 3'd1;
  localparam logic [2:0] IDX_COUNT  = 3'd2;
  localparam logic [2:0] IDX_CMP    = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;
  localparam logic [2:0] IDX_CAPT   = 3'd5;

  logic [2:0]             ctrl_q,  ctrl_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [DATA_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0]  cmp_q,   cmp_d;
  logic                   match_q, match_d;
  logic [PRESC_WIDTH-1:0] pcnt_q,  pcnt_d;

  logic [2:0]            reg_idx;
  logic [DATA_WIDTH-1:0] wdat;
  logic                  wr_acc, rd_acc;
  logic                  wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
  logic                  en_eff, tick, hit;
  logic                  status_capf;
  logic [DATA_WIDTH-1:0] capt_val;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_addr;

  assign reg_idx     = bus.addr_bus_slv[REG_ADDR_LSB+2:REG_ADDR_LSB];
  assign unused_addr = ^{bus.addr_bus_slv[DATA_WIDTH-1:REG_ADDR_LSB+3],
                         bus.addr_bus_slv[REG_ADDR_LSB-1:0]};
  assign wdat        = data_bus_slv;
  assign wr_acc      = bus.valid_ctrl_slv & ~bus.we_ctrl_slv;
  assign rd_acc      = bus.valid_ctrl_slv &  bus.we_ctrl_slv;
  assign wr_ctrl     = wr_acc & (reg_idx == IDX_CTRL);
  assign wr_presc    = wr_acc & (reg_idx == IDX_PRESC);
  assign wr_count    = wr_acc & (reg_idx == IDX_COUNT);
  assign wr_cmp      = wr_acc & (reg_idx == IDX_CMP);
  assign wr_status   = wr_acc & (reg_idx == IDX_STATUS);

  // A CTRL write takes effect on its own edge, so a disabling write suppresses the tick.
  assign en_eff = wr_ctrl ? wdat[0] : ctrl_q[0];
  assign tick   = en_eff & (pcnt_q == presc_q);
  assign hit    = tick & (count_q == cmp_q);

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    pcnt_d  = pcnt_q + PRESC_WIDTH'(1);

    if (!en_eff || tick || wr_presc || wr_count) begin
      pcnt_d = '0;
    end

    if (wr_count) begin
      count_d = wdat;
    end else if (tick) begin
      count_d = (hit && ctrl_q[1]) ? '0 : count_q + DATA_WIDTH'(1);
    end

    // Set has priority over a write-1-to-clear in the same cycle.
    match_d = hit | (match_q & ~(wr_status & wdat[0]));

    if (wr_ctrl)  ctrl_d  = wdat[2:0];
    if (wr_presc) presc_d = wdat[PRESC_WIDTH-1:0];
    if (wr_cmp)   cmp_d   = wdat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      match_q <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      pcnt_q  <= pcnt_d;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]            cap_sync_q, cap_sync_d;
  logic [DATA_WIDTH-1:0] capt_q,     capt_d;
  logic                  capf_q,     capf_d;
  logic                  cap_rise;

  // Two synchronizer flops plus one history flop for edge detection.
  assign cap_rise = cap_sync_q[1] & ~cap_sync_q[2];

  always_comb begin
    cap_sync_d = {cap_sync_q[1:0], cap_in};
    capt_d     = cap_rise ? count_q : capt_q;
    capf_d     = cap_rise | (capf_q & ~(wr_status & wdat[1]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_sync_q <= '0;
      capt_q     <= '0;
      capf_q     <= 1'b0;
    end else begin
      cap_sync_q <= cap_sync_d;
      capt_q     <= capt_d;
      capf_q     <= capf_d;
    end
  end

  assign status_capf = capf_q;
  assign capt_val    = capt_q;
  assign irq         = (match_q | capf_q) & ctrl_q[2];
`else
  assign status_capf = 1'b0;
  assign capt_val    = '0;
  assign irq         = match_q & ctrl_q[2];
`endif

  always_comb begin
    rdata = '0;
    case (reg_idx)
      IDX_CTRL:   rdata = {{(DATA_WIDTH-3){1'b0}}, ctrl_q};
      IDX_PRESC:  rdata = DATA_WIDTH'(presc_q);
      IDX_COUNT:  rdata = count_q;
      IDX_CMP:    rdata = cmp_q;
      IDX_STATUS: rdata = {{(DATA_WIDTH-2){1'b0}}, status_capf, match_q};
      IDX_CAPT:   rdata = capt_val;
      default:    rdata = '0;
    endcase
  end

  assign data_bus_slv = rd_acc ? rdata : 'z;

endmodule

// File: tb/tb_bus_timer_slv.sv
module tb_bus_timer_slv;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          irq;
  logic [DW-1:0] tb_dat;
  logic          tb_drv;
  wire  [DW-1:0] data_bus;
  assign data_bus = tb_drv ? tb_dat : 'z;

  bus_timer_slv_if #(.DATA_WIDTH(DW)) bus ();

`ifdef TIMER_CAPTURE_EN
  logic cap_in;
`endif

  bus_timer_slv #(.DATA_WIDTH(DW), .PRESC_WIDTH(16), .REG_ADDR_LSB(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .data_bus_slv (data_bus),
`ifdef TIMER_CAPTURE_EN
    .cap_in       (cap_in),
`endif
    .irq          (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (register contents plus prescaler phase)
  logic [2:0]  m_ctrl;
  logic [15:0] m_presc;
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic        m_match;
  logic [15:0] m_pcnt;

  task automatic model_reset();
    m_ctrl = '0; m_presc = '0; m_count = '0; m_cmp = '0; m_match = 1'b0; m_pcnt = '0;
  endtask

  function automatic logic [31:0] model_read(input int idx);
    case (idx)
      0:       return {29'd0, m_ctrl};
      1:       return {16'd0, m_presc};
      2:       return m_count;
      3:       return m_cmp;
      4:       return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_irq();
    return m_match & m_ctrl[2];
  endfunction

  // One rising edge of the timer, given the bus access present during that cycle.
  task automatic model_step(input bit wr, input int idx, input logic [31:0] dat);
    bit en, tick, hit;
    en   = (wr && idx == 0) ? dat[0] : m_ctrl[0];
    tick = en && (m_pcnt == m_presc);
    hit  = tick && (m_count == m_cmp);
    if (!en || tick || (wr && (idx == 1 || idx == 2))) m_pcnt = 16'd0;
    else m_pcnt = m_pcnt + 16'd1;
    if (wr && idx == 2) m_count = dat;
    else if (tick) m_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    m_match = hit || (m_match && !(wr && idx == 4 && dat[0]));
    if (wr && idx == 0) m_ctrl  = dat[2:0];
    if (wr && idx == 1) m_presc = dat[15:0];
    if (wr && idx == 3) m_cmp   = dat;
  endtask

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a;
    a        = $urandom;
    a[31:30] = 2'b00;
    a[4:2]   = idx[2:0];
    return a;
  endfunction

  task automatic do_write(input int idx, input logic [31:0] dat);
    bus.addr_bus_slv   = mk_addr(idx);
    bus.we_ctrl_slv    = 1'b0;
    bus.valid_ctrl_slv = 1'b1;
    tb_dat = dat;
    tb_drv = 1'b1;
    @(posedge clk);
    model_step(1'b1, idx, dat);
    #1;
    bus.valid_ctrl_slv = 1'b0;
    bus.we_ctrl_slv    = 1'b1;
    tb_drv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step(1'b0, 0, 32'd0);
      #1;
    end
  endtask

  task automatic peek(input int idx, output logic [31:0] v);
    bus.addr_bus_slv   = mk_addr(idx);
    bus.we_ctrl_slv    = 1'b1;
    bus.valid_ctrl_slv = 1'b1;
    tb_drv = 1'b0;
    #1;
    v = data_bus;
    bus.valid_ctrl_slv = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_write(0, 32'h7);
    do_write(3, 32'h5);
    idle(3);
    // A write pending while reset is low must be discarded
    bus.addr_bus_slv = mk_addr(0); bus.we_ctrl_slv = 1'b0; bus.valid_ctrl_slv = 1'b1;
    tb_dat = 32'h7; tb_drv = 1'b1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; bus.valid_ctrl_slv = 1'b0; bus.we_ctrl_slv = 1'b1; tb_drv = 1'b0;
    model_reset();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    for (int i = 0; i < 6; i++) begin
      peek(i, v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0", i, v); end
    end
    #1;
    checks++;
    if (!(data_bus === 32'd0 || data_bus === 'z))
      begin errors++; $display("FAIL reset_hiz: got %h expected z", data_bus); end
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    do_write(1, 32'd3);
    do_write(3, 32'hFFFF_FFFF);
    do_write(2, 32'd0);
    do_write(0, 32'h1);
    idle(40);
    peek(2, v);
    checks++;
    if (v !== model_read(2)) begin errors++; $display("FAIL presc_count: got %0d expected %0d", v, model_read(2)); end
    checks++;
    if (v < 9 || v > 11) begin errors++; $display("FAIL presc_range: got %0d expected 10+-1", v); end
    // No driver on the bus when the access strobe is low
    bus.we_ctrl_slv = 1'b1; bus.valid_ctrl_slv = 1'b0; #1;
    checks++;
    if (!(data_bus === 32'd0 || data_bus === 'z))
      begin errors++; $display("FAIL idle_hiz: got %h expected z", data_bus); end
  endtask

  task automatic test_autoreload();
    logic [31:0] v, prev;
    do_write(0, 32'h0);
    do_write(4, 32'h1);
    do_write(1, 32'h0);
    do_write(3, 32'd4);
    do_write(2, 32'd0);
    do_write(0, 32'h7);
    prev = 32'hDEAD;
    for (int i = 0; i < 6; i++) begin
      peek(2, v);
      checks++;
      if (v !== model_read(2)) begin errors++; $display("FAIL ar_count%0d: got %0d expected %0d", i, v, model_read(2)); end
      checks++;
      if (irq !== model_irq()) begin errors++; $display("FAIL ar_irq%0d: got %b expected %b", i, irq, model_irq()); end
      if (prev == 32'd4) begin
        checks++;
        if (v !== 32'd0 || irq !== 1'b1)
          begin errors++; $display("FAIL ar_reload: got count %0d irq %b expected 0 1", v, irq); end
      end
      prev = v;
      idle(1);
    end
    do_write(4, 32'h1);
    checks++;
    if (irq !== 1'b0 || model_irq() !== 1'b0)
      begin errors++; $display("FAIL ar_w1c_irq: got %b expected 0", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    do_write(0, 32'h0);
    do_write(4, 32'h1);
    do_write(1, 32'h0);
    do_write(2, 32'd0);
    do_write(3, 32'd2);
    do_write(0, 32'h5);
    idle(1);
    do_write(4, 32'h1);
    peek(4, v);
    checks++;
    if (v[0] !== 1'b1 || v !== model_read(4)) begin errors++; $display("FAIL col_match: got %h expected 1", v); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL col_irq: got %b expected 1", irq); end
    do_write(2, 32'h100);
    peek(2, v);
    checks++;
    if (v !== 32'h100 || v !== model_read(2)) begin errors++; $display("FAIL col_count_wr: got %h expected 100", v); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    do_write(0, 32'h0);
    do_write(4, 32'h1);
    do_write(1, 32'h0);
    do_write(3, 32'hFFFF_FFFF);
    do_write(2, 32'hFFFF_FFFE);
    do_write(0, 32'h1);
    peek(2, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffffffff", v); end
    idle(1);
    peek(2, v);
    checks++;
    if (v !== 32'h0 || v !== model_read(2)) begin errors++; $display("FAIL wrap_zero: got %h expected 0", v); end
    peek(4, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL wrap_match: got %h expected 1", v); end
    idle(1);
    peek(2, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL wrap_one: got %h expected 1", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq: got %b expected 0", irq); end
  endtask

  task automatic test_random();
    logic [31:0] v, d;
    int op, idx;
    for (int n = 0; n < 400; n++) begin
      op  = $urandom_range(0, 9);
      idx = $urandom_range(0, 7);
      if (op < 4) begin
        d = $urandom;
        if (idx == 1) d[15:0] = 16'($urandom_range(0, 3));
        if (idx == 2 || idx == 3) d = $urandom_range(0, 12);
        do_write(idx, d);
      end else if (op < 7) begin
        peek(idx, v);
        checks++;
        if (v !== model_read(idx))
          begin errors++; $display("FAIL rnd_read%0d idx%0d: got %h expected %h", n, idx, v, model_read(idx)); end
        idle(1);
      end else begin
        idle(1);
      end
      checks++;
      if (irq !== model_irq()) begin errors++; $display("FAIL rnd_irq%0d: got %b expected %b", n, irq, model_irq()); end
    end
  endtask

`ifdef TIMER_CAPTURE_EN
  task automatic test_capture();
    logic [31:0] v;
    bit found;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cap_in = 1'b0;
    do_write(1, 32'h0);
    do_write(2, 32'h0);
    do_write(0, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      peek(2, v);
      if (v == 32'd20) found = 1'b1;
      else idle(1);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL cap_reach20: got %0d expected 20", v); end
    cap_in = 1'b1;
    idle(6);
    peek(5, v);
    checks++;
    if (v !== 32'd22 && v !== 32'd23) begin errors++; $display("FAIL cap_value: got %0d expected 22 or 23", v); end
    peek(4, v);
    checks++;
    if (v[1] !== 1'b1) begin errors++; $display("FAIL cap_flag: got %h expected bit1=1", v); end
    peek(6, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL cap_unmapped: got %h expected 0", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL cap_irq: got %b expected 0", irq); end
    do_write(4, 32'h2);
    peek(4, v);
    checks++;
    if (v[1] !== 1'b0) begin errors++; $display("FAIL cap_w1c: got %h expected bit1=0", v); end
  endtask
`else
  task automatic test_no_capture();
    logic [31:0] v;
    do_write(5, 32'h1234_5678);
    peek(5, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL nocap_capt: got %h expected 0", v); end
    peek(4, v);
    checks++;
    if (v[31:1] !== 31'd0) begin errors++; $display("FAIL nocap_status: got %h expected bits31:1=0", v); end
    peek(6, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL nocap_unmapped: got %h expected 0", v); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    tb_drv = 1'b0;
    tb_dat = '0;
    bus.addr_bus_slv   = '0;
    bus.we_ctrl_slv    = 1'b1;
    bus.valid_ctrl_slv = 1'b0;
`ifdef TIMER_CAPTURE_EN
    cap_in = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_prescale();
    test_autoreload();
    test_collision();
    test_wrap();
    test_random();
`ifdef TIMER_CAPTURE_EN
    test_capture();
`else
    test_no_capture();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
